// File: rtl/fp_mul_seq_if.sv
// Handshake and operand/result bundle for the sequential floating-point multiplier.
interface fp_mul_seq_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] product;
  logic [3:0]   flags;

  modport master (output start, a, b, input busy, done, product, flags);
  modport slave  (input start, a, b, output busy, done, product, flags);
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-style multiplier: shift-add significand product, RNE rounding,
// fixed latency regardless of operand class. Subnormals are flushed to zero.
module fp_mul_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic         clk,
  input logic         reset,
  fp_mul_seq_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 2);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ZERO = '0;
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

  state_t        stateReg;
  logic [W-1:0]  aReg, bReg;
  logic [PW-1:0] accReg, mcandReg;
  logic [MAN_W:0] mplierReg;
  logic [CW-1:0] cntReg;
  logic [W-1:0]  resReg, productReg;
  logic [3:0]    resFlagsReg, flagsReg;
  logic          busyReg, doneReg;

  logic [EXP_W-1:0] expA, expB;
  logic [MAN_W-1:0] fracA, fracB;
  logic aZero, bZero, aInf, bInf, aNan, bNan, sgn;
  logic signed [EW-1:0] eSum, eNorm, eFinal;
  logic [MAN_W-1:0] fracPre, fracRnd;
  logic guard, sticky, roundUp, carry;
  logic [W-1:0] resNext;
  logic [3:0]   flagsNext;

  assign expA  = aReg[W-2 -: EXP_W];
  assign expB  = bReg[W-2 -: EXP_W];
  assign fracA = aReg[MAN_W-1:0];
  assign fracB = bReg[MAN_W-1:0];
  assign aZero = (expA == '0);
  assign bZero = (expB == '0);
  assign aInf  = (expA == '1) && (fracA == '0);
  assign bInf  = (expB == '1) && (fracB == '0);
  assign aNan  = (expA == '1) && (fracA != '0);
  assign bNan  = (expB == '1) && (fracB != '0);
  assign sgn   = aReg[W-1] ^ bReg[W-1];

  always_comb begin
    eSum = $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS;
    // Product of two [1,2) significands lies in [1,4); bit PW-1 marks the [2,4) half.
    if (accReg[PW-1]) begin
      fracPre = accReg[PW-2 -: MAN_W];
      guard   = accReg[MAN_W];
      sticky  = |accReg[MAN_W-1:0];
      eNorm   = eSum + ONE;
    end else begin
      fracPre = accReg[PW-3 -: MAN_W];
      guard   = accReg[MAN_W-1];
      sticky  = |accReg[MAN_W-2:0];
      eNorm   = eSum;
    end
    roundUp          = guard & (sticky | fracPre[0]);
    {carry, fracRnd} = {1'b0, fracPre} + {{MAN_W{1'b0}}, roundUp};
    eFinal           = carry ? eNorm + ONE : eNorm;

    resNext   = {sgn, eFinal[EXP_W-1:0], fracRnd};
    flagsNext = {3'b000, guard | sticky};
    if (aNan || bNan) begin
      resNext   = QNAN;
      flagsNext = 4'b0000;
    end else if ((aInf && bZero) || (bInf && aZero)) begin
      resNext   = QNAN;
      flagsNext = 4'b1000;
    end else if (aInf || bInf) begin
      resNext   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flagsNext = 4'b0000;
    end else if (aZero || bZero) begin
      resNext   = {sgn, {(W-1){1'b0}}};
      flagsNext = 4'b0000;
    end else if (eFinal >= EMAX) begin
      resNext   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flagsNext = 4'b0101;
    end else if (eFinal <= ZERO) begin
      resNext   = {sgn, {(W-1){1'b0}}};
      flagsNext = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      aReg        <= '0;
      bReg        <= '0;
      accReg      <= '0;
      mcandReg    <= '0;
      mplierReg   <= '0;
      cntReg      <= '0;
      resReg      <= '0;
      resFlagsReg <= '0;
      productReg  <= '0;
      flagsReg    <= '0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (bus.start) begin
            aReg      <= bus.a;
            bReg      <= bus.b;
            accReg    <= '0;
            mcandReg  <= PW'({1'b1, bus.a[MAN_W-1:0]});
            mplierReg <= {1'b1, bus.b[MAN_W-1:0]};
            cntReg    <= '0;
            busyReg   <= 1'b1;
            stateReg  <= MUL;
          end
        end
        MUL: begin
          if (mplierReg[0]) accReg <= accReg + mcandReg;
          mcandReg  <= mcandReg << 1;
          mplierReg <= mplierReg >> 1;
          cntReg    <= cntReg + CW'(1);
          if (cntReg == CW'(MAN_W)) stateReg <= ROUND;
        end
        ROUND: begin
          resReg      <= resNext;
          resFlagsReg <= flagsNext;
          stateReg    <= DONE;
        end
        DONE: begin
          productReg <= resReg;
          flagsReg   <= resFlagsReg;
          doneReg    <= 1'b1;
          busyReg    <= 1'b0;
          stateReg   <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busyReg;
  assign bus.done    = doneReg;
  assign bus.product = productReg;
  assign bus.flags   = flagsReg;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq: half-precision table, control corner cases,
// and a single-precision instance for the wide-parameter latency.
module tb_fp_mul_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_mul_seq_if #(.EXP_W(5), .MAN_W(10)) bus16 ();
  fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus32 ();

  fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] p, output logic [3:0] f, output int lat);
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    check("busy_after_start16", 32'(bus16.busy), 32'd1);
    lat = 0;
    while (bus16.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    p = bus16.product; f = bus16.flags;
    check("busy_low_at_done16", 32'(bus16.busy), 32'd0);
    @(posedge clk); #1;
    check("done_single_cycle16", 32'(bus16.done), 32'd0);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] p, output logic [3:0] f, output int lat);
    @(negedge clk);
    bus32.a = a; bus32.b = b; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    lat = 0;
    while (bus32.done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    p = bus32.product; f = bus32.flags;
  endtask

  initial begin
    logic [15:0] p16;
    logic [31:0] p32;
    logic [3:0]  f;
    int          lat;
    int          nDone, firstEdge, secondEdge;
    logic [15:0] firstProd, secondProd;
    logic        sawDone;

    vecs[0]  = '{16'h3C00, 16'h3C00, 16'h3C00, 4'b0000};
    vecs[1]  = '{16'h4000, 16'hC200, 16'hC600, 4'b0000};
    vecs[2]  = '{16'h3C01, 16'h3E00, 16'h3E02, 4'b0001};
    vecs[3]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101};
    vecs[4]  = '{16'h0400, 16'h0400, 16'h0000, 4'b0011};
    vecs[5]  = '{16'h7C00, 16'h0000, 16'h7E00, 4'b1000};
    vecs[6]  = '{16'h7E01, 16'h3C00, 16'h7E00, 4'b0000};
    vecs[7]  = '{16'h7C00, 16'hC000, 16'hFC00, 4'b0000};
    vecs[8]  = '{16'h8000, 16'h4000, 16'h8000, 4'b0000};
    vecs[9]  = '{16'h0001, 16'h3C00, 16'h0000, 4'b0000};
    vecs[10] = '{16'h3E00, 16'h3E00, 16'h4080, 4'b0000};
    vecs[11] = '{16'h0000, 16'h7C00, 16'h7E00, 4'b1000};
    vecs[12] = '{16'h7C00, 16'h7C00, 16'h7C00, 4'b0000};
    vecs[13] = '{16'h7C01, 16'h7C00, 16'h7E00, 4'b0000};
    vecs[14] = '{16'h3DA8, 16'h3DA8, 16'h4000, 4'b0001};
    vecs[15] = '{16'h2000, 16'h1C00, 16'h0000, 4'b0011};
    vecs[16] = '{16'h2000, 16'h2000, 16'h0400, 4'b0000};
    vecs[17] = '{16'h7800, 16'h3C00, 16'h7800, 4'b0000};
    vecs[18] = '{16'h7800, 16'h4000, 16'h7C00, 4'b0101};
    vecs[19] = '{16'hF800, 16'h4000, 16'hFC00, 4'b0101};
    vecs[20] = '{16'h3BFF, 16'h3C01, 16'h3C00, 4'b0001};

    // Reset with start asserted: reset must win.
    reset = 1'b1;
    bus16.start = 1'b1; bus16.a = 16'h3C00; bus16.b = 16'h3C00;
    bus32.start = 1'b0; bus32.a = '0; bus32.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus16.busy), 32'd0);
    check("reset_done", 32'(bus16.done), 32'd0);
    check("reset_product", 32'(bus16.product), 32'h0);
    check("reset_flags", 32'(bus16.flags), 32'h0);
    bus16.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      run16(vecs[i].a, vecs[i].b, p16, f, lat);
      $display("vec %0d: a=%h b=%h product=%h flags=%b latency=%0d",
               i, vecs[i].a, vecs[i].b, p16, f, lat);
      check($sformatf("latency_v%0d", i), 32'(lat), 32'd13);
      check($sformatf("product_v%0d", i), 32'(p16), 32'(vecs[i].p));
      check($sformatf("flags_v%0d", i), 32'(f), 32'(vecs[i].f));
    end

    // Reset at the fifth edge after acceptance aborts the operation.
    @(negedge clk);
    bus16.a = 16'h3C00; bus16.b = 16'h4000; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 32'(bus16.busy), 32'd0);
    sawDone = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus16.done) sawDone = 1'b1;
    end
    $display("abort: busy=%b done_seen=%b product=%h flags=%b",
             bus16.busy, sawDone, bus16.product, bus16.flags);
    check("abort_no_done", 32'(sawDone), 32'd0);
    check("abort_product", 32'(bus16.product), 32'h0);
    check("abort_flags", 32'(bus16.flags), 32'h0);

    // Start held high; operand change after acceptance must not leak in.
    @(negedge clk);
    bus16.a = 16'h3C00; bus16.b = 16'h4000; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.a = 16'h4200;
    nDone = 0; firstEdge = 0; secondEdge = 0; firstProd = '0; secondProd = '0;
    for (int e = 1; e <= 27; e++) begin
      @(posedge clk); #1;
      if (bus16.done) begin
        nDone++;
        if (nDone == 1) begin firstEdge = e; firstProd = bus16.product; end
        else if (nDone == 2) begin secondEdge = e; secondProd = bus16.product; end
      end
    end
    bus16.start = 1'b0;
    $display("held start: dones=%0d first@%0d=%h second@%0d=%h",
             nDone, firstEdge, firstProd, secondEdge, secondProd);
    check("held_done_count", 32'(nDone), 32'd2);
    check("held_first_edge", 32'(firstEdge), 32'd13);
    check("held_first_product", 32'(firstProd), 32'h4000);
    check("held_second_edge", 32'(secondEdge), 32'd27);
    check("held_second_product", 32'(secondProd), 32'h4600);
    repeat (3) @(posedge clk);
    #1;
    check("held_idle_after", 32'(bus16.busy), 32'd0);

    // Single-precision parameterisation.
    run32(32'h3F800000, 32'h3F800000, p32, f, lat);
    $display("sp: a=3f800000 b=3f800000 product=%h flags=%b latency=%0d", p32, f, lat);
    check("sp_latency", 32'(lat), 32'd26);
    check("sp_product", p32, 32'h3F800000);
    check("sp_flags", 32'(f), 32'h0);
    run32(32'h40000000, 32'h40400000, p32, f, lat);
    $display("sp: a=40000000 b=40400000 product=%h flags=%b latency=%0d", p32, f, lat);
    check("sp_latency2", 32'(lat), 32'd26);
    check("sp_product2", p32, 32'h40C00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
